// File: rtl/rf2p_burst_reader_if.sv
// Bundles the command, RF read and output stream signals of the RF2P burst reader.
//   master : the burst reader itself (consumes commands/RF data, drives RF reads/stream)
//   slave  : the environment (command source, RF2P macro/model, downstream consumer)
// Signals:
//   i_cmd_valid/o_cmd_ready/i_cmd_base/i_cmd_len : burst command handshake
//   o_rf_read/o_rf_raddr/i_rf_rdata/i_rf_rvalid  : RF2P read port (1-cycle latency)
//   o_dat_valid/i_dat_ready/o_dat/o_dat_last     : output word stream
//   o_busy/o_done                                : status
interface rf2p_burst_reader_if #(
  parameter int DWD = 16,
  parameter int AWD = 6,
  parameter int LWD = AWD + 1
);
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [AWD-1:0] i_cmd_base;
  logic [LWD-1:0] i_cmd_len;
  logic           o_rf_read;
  logic [AWD-1:0] o_rf_raddr;
  logic [DWD-1:0] i_rf_rdata;
  logic           i_rf_rvalid;
  logic           o_dat_valid;
  logic           i_dat_ready;
  logic [DWD-1:0] o_dat;
  logic           o_dat_last;
  logic           o_busy;
  logic           o_done;

  modport master (
    input  i_cmd_valid, i_cmd_base, i_cmd_len, i_rf_rdata, i_rf_rvalid, i_dat_ready,
    output o_cmd_ready, o_rf_read, o_rf_raddr, o_dat_valid, o_dat, o_dat_last, o_busy, o_done
  );

  modport slave (
    output i_cmd_valid, i_cmd_base, i_cmd_len, i_rf_rdata, i_rf_rvalid, i_dat_ready,
    input  o_cmd_ready, o_rf_read, o_rf_raddr, o_dat_valid, o_dat, o_dat_last, o_busy, o_done
  );
endinterface

// File: rtl/rf2p_burst_reader.sv
// Read-side initiator for a two-port register file. Accepts a burst command
// (base, len), issues sequential RF reads (address wraps modulo 2**AWD) and
// streams the returned words out over a valid/ready port with a last flag.
// A 2-entry output FIFO absorbs the fixed 1-cycle RF read latency; reads are
// only issued when the FIFO is guaranteed to have room for the returning word.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : rf2p_burst_reader_if.master (command, RF read port, output stream, status)
module rf2p_burst_reader #(
  parameter int DWD = 16,
  parameter int AWD = 6,
  parameter int LWD = AWD + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rf2p_burst_reader_if.master   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [AWD-1:0] addr;
  logic [LWD-1:0] remaining;
  logic           outstanding;
  logic           outstanding_last;
  logic [1:0]     fifo_count;
  logic [DWD-1:0] head_dat;
  logic           head_last;
  logic [DWD-1:0] tail_dat;
  logic           tail_last;
  logic           done;

  logic cmd_fire;
  logic pop;
  logic push;
  logic credit_ok;
  logic issue;
  logic last_issue;
  logic last_pop;

  assign cmd_fire = bus.i_cmd_valid && (state == ST_IDLE);
  assign pop      = (fifo_count != 2'd0) && bus.i_dat_ready;
  // Data arriving with no read in flight (e.g. just after reset) is dropped.
  assign push     = bus.i_rf_rvalid && outstanding;

  // Words held or in flight, minus the one leaving this cycle, must stay below
  // the FIFO depth so the returning word always has a slot.
  assign credit_ok  = ({1'b0, fifo_count} + {2'b00, outstanding}) < (3'd2 + {2'b00, pop});
  assign issue      = (state == ST_RUN) && (remaining != '0) && credit_ok;
  assign last_issue = issue && (remaining == LWD'(1));
  assign last_pop   = pop && head_last;

  assign bus.o_cmd_ready = (state == ST_IDLE);
  assign bus.o_rf_read   = issue;
  assign bus.o_rf_raddr  = addr;
  assign bus.o_dat_valid = (fifo_count != 2'd0);
  assign bus.o_dat       = head_dat;
  assign bus.o_dat_last  = head_last;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_done      = done;

  // Burst sequencing: address/length bookkeeping and the IDLE/RUN/DRAIN flow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= (cmd_fire && (bus.i_cmd_len == '0)) || last_pop;
      case (state)
        ST_IDLE: begin
          if (cmd_fire && (bus.i_cmd_len != '0)) begin
            state     <= ST_RUN;
            addr      <= bus.i_cmd_base;
            remaining <= bus.i_cmd_len;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr      <= addr + AWD'(1);
            remaining <= remaining - LWD'(1);
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_pop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-cycle RF latency: the read issued now returns next cycle, and it
  // carries the last flag if it was the final read of the burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding      <= 1'b0;
      outstanding_last <= 1'b0;
    end else begin
      outstanding      <= issue;
      outstanding_last <= last_issue;
    end
  end

  // Two-entry FIFO with a registered head; the head only changes on a pop or
  // when a word lands in an empty FIFO, so it holds steady under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_count <= 2'd0;
      head_dat   <= '0;
      head_last  <= 1'b0;
      tail_dat   <= '0;
      tail_last  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            head_dat  <= bus.i_rf_rdata;
            head_last <= outstanding_last;
          end else begin
            tail_dat  <= bus.i_rf_rdata;
            tail_last <= outstanding_last;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          head_dat   <= tail_dat;
          head_last  <= tail_last;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            head_dat  <= bus.i_rf_rdata;
            head_last <= outstanding_last;
          end else begin
            head_dat  <= tail_dat;
            head_last <= tail_last;
            tail_dat  <= bus.i_rf_rdata;
            tail_last <= outstanding_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf2p_burst_reader.sv
// Self-checking bench for rf2p_burst_reader. An RF model answers reads one
// cycle later; a reference model tracks, in terms of words issued/popped and a
// queue of expected words, what the reader must do every cycle. A table of
// bursts (fixed corner cases plus random ones) is applied in a loop, followed
// by hand-written sequences for latency, command blocking and mid-burst reset.
module tb_rf2p_burst_reader;
  localparam int DWD = 16;
  localparam int AWD = 6;
  localparam int LWD = 7;
  localparam int DEPTH = 64;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  rf2p_burst_reader_if #(.DWD(DWD), .AWD(AWD), .LWD(LWD)) bus ();

  rf2p_burst_reader #(.DWD(DWD), .AWD(AWD), .LWD(LWD)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DWD-1:0] mem [DEPTH];

  typedef struct {
    logic [AWD-1:0] base;
    logic [LWD-1:0] len;
    int             mode;
    int             exp_words;
    logic [AWD-1:0] exp_last_addr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Stimulus-side controls
  int ready_mode = 0;
  int cyc = 0;
  bit inject_stray = 1'b0;
  bit rd_q = 1'b0;
  logic [AWD-1:0] addr_q = '0;

  // Reference model state
  logic [DWD-1:0] exp_dat_q [$];
  bit             exp_last_q [$];
  int             to_issue = 0;
  int             inflight = 0;
  logic [AWD-1:0] next_addr = '0;
  bit             model_busy = 1'b0;
  bit             done_exp = 1'b0;
  bit             done_next = 1'b0;
  int             burst_reads = 0;
  int             burst_pops = 0;
  logic [DWD-1:0] last_pop_dat = '0;
  bit             prev_stall = 1'b0;
  logic [DWD-1:0] prev_dat = '0;
  logic           prev_last = 1'b0;
  bit             pop_now;
  bit             exp_read;
  logic [DWD-1:0] want_dat;
  bit             want_last;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RF model: capture the read mid-cycle, answer during the following cycle.
  always @(negedge i_clk) begin
    rd_q   = bus.o_rf_read;
    addr_q = bus.o_rf_raddr;
  end

  always @(posedge i_clk) begin
    #1;
    bus.i_rf_rvalid = rd_q | inject_stray;
    bus.i_rf_rdata  = rd_q ? mem[addr_q] : DWD'($urandom);
    inject_stray    = 1'b0;
  end

  // Downstream ready: always, the 1,0,0 pattern, or random.
  always @(posedge i_clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       bus.i_dat_ready = 1'b1;
      1:       bus.i_dat_ready = ((cyc % 3) == 0);
      default: bus.i_dat_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      checkOutput("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
      checkOutput("rst_rf_read",   32'(bus.o_rf_read),   32'd0);
      checkOutput("rst_rf_raddr",  32'(bus.o_rf_raddr),  32'd0);
      checkOutput("rst_dat_valid", 32'(bus.o_dat_valid), 32'd0);
      checkOutput("rst_dat",       32'(bus.o_dat),       32'd0);
      checkOutput("rst_dat_last",  32'(bus.o_dat_last),  32'd0);
      checkOutput("rst_busy",      32'(bus.o_busy),      32'd0);
      checkOutput("rst_done",      32'(bus.o_done),      32'd0);
      exp_dat_q.delete();
      exp_last_q.delete();
      to_issue    = 0;
      inflight    = 0;
      model_busy  = 1'b0;
      done_exp    = 1'b0;
      done_next   = 1'b0;
      burst_reads = 0;
      burst_pops  = 0;
      prev_stall  = 1'b0;
    end else begin
      pop_now  = bus.o_dat_valid && bus.i_dat_ready;
      // A read is due whenever words remain and fewer than two would be held.
      exp_read = (to_issue > 0) && ((inflight - int'(pop_now)) < 2);
      checkOutput("rf_read",   32'(bus.o_rf_read),   32'(exp_read));
      checkOutput("cmd_ready", 32'(bus.o_cmd_ready), 32'(!model_busy));
      checkOutput("busy",      32'(bus.o_busy),      32'(model_busy));
      checkOutput("done",      32'(bus.o_done),      32'(done_exp));
      if (bus.o_dat_valid) checkOutput("valid_has_data", 32'(inflight > 0), 32'd1);
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(bus.o_dat_valid), 32'd1);
        checkOutput("stall_dat",   32'(bus.o_dat),       32'(prev_dat));
        checkOutput("stall_last",  32'(bus.o_dat_last),  32'(prev_last));
      end
      if (bus.o_rf_read) begin
        checkOutput("rf_raddr", 32'(bus.o_rf_raddr), 32'(next_addr));
        next_addr = next_addr + AWD'(1);
        if (to_issue > 0) to_issue--;
        inflight++;
        burst_reads++;
      end
      if (pop_now) begin
        if (exp_dat_q.size() == 0) begin
          checkOutput("unexpected_word", 32'(bus.o_dat), 32'hFFFF_FFFF);
        end else begin
          want_dat  = exp_dat_q.pop_front();
          want_last = exp_last_q.pop_front();
          checkOutput("dat",      32'(bus.o_dat),      32'(want_dat));
          checkOutput("dat_last", 32'(bus.o_dat_last), 32'(want_last));
          if (want_last) begin
            model_busy = 1'b0;
            done_next  = 1'b1;
          end
        end
        inflight--;
        burst_pops++;
        last_pop_dat = bus.o_dat;
      end
      if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        burst_reads = 0;
        burst_pops  = 0;
        if (bus.i_cmd_len == '0) begin
          done_next = 1'b1;
        end else begin
          model_busy = 1'b1;
          to_issue   = int'(bus.i_cmd_len);
          next_addr  = bus.i_cmd_base;
          for (int i = 0; i < int'(bus.i_cmd_len); i++) begin
            exp_dat_q.push_back(mem[(int'(bus.i_cmd_base) + i) % DEPTH]);
            exp_last_q.push_back(i == int'(bus.i_cmd_len) - 1);
          end
        end
      end
      prev_stall = bus.o_dat_valid && !bus.i_dat_ready;
      prev_dat   = bus.o_dat;
      prev_last  = bus.o_dat_last;
      done_exp   = done_next;
      done_next  = 1'b0;
    end
  end

  task automatic startCmd(input logic [AWD-1:0] base, input logic [LWD-1:0] len);
    int g = 0;
    while (!bus.o_cmd_ready && g < 400) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 400) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_base  = base;
    bus.i_cmd_len   = len;
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    int g = 0;
    do begin
      @(negedge i_clk);
      g++;
    end while (!bus.o_done && g < 400);
    if (!bus.o_done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [AWD-1:0] base, input logic [LWD-1:0] len);
    startCmd(base, len);
    waitDone();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int g;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_base  = '0;
    bus.i_cmd_len   = '0;
    bus.i_rf_rvalid = 1'b0;
    bus.i_rf_rdata  = '0;
    bus.i_dat_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DWD'($urandom);

    vecs[0] = '{6'h10, 7'd4,  0, 4,  6'h13};
    vecs[1] = '{6'h00, 7'd8,  1, 8,  6'h07};
    vecs[2] = '{6'h3E, 7'd4,  0, 4,  6'h01};
    vecs[3] = '{6'h00, 7'd0,  0, 0,  6'h00};
    vecs[4] = '{6'h05, 7'd64, 0, 64, 6'h04};
    vecs[5] = '{6'h21, 7'd5,  2, 5,  6'h25};
    vecs[6] = '{6'h3F, 7'd1,  1, 1,  6'h3F};
    for (int v = 7; v < NV; v++) begin
      vecs[v].base          = AWD'($urandom);
      vecs[v].len           = LWD'($urandom_range(0, 12));
      vecs[v].mode          = int'($urandom_range(0, 2));
      vecs[v].exp_words     = int'(vecs[v].len);
      vecs[v].exp_last_addr = AWD'(int'(vecs[v].base) + int'(vecs[v].len) - 1);
    end

    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // First word appears on the second clock edge after the handshake edge,
    // i.e. it is visible at the third mid-cycle sample.
    ready_mode = 0;
    startCmd(6'h10, 7'd4);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!bus.o_dat_valid && n < 10);
    checkOutput("first_valid_latency", 32'(n), 32'd3);
    waitDone();
    checkOutput("t1_words", 32'(burst_pops), 32'd4);

    // Table of bursts applied in a loop
    for (int v = 0; v < NV; v++) begin
      ready_mode = vecs[v].mode;
      applyStimulus(vecs[v].base, vecs[v].len);
      checkOutput("burst_words", 32'(burst_pops), 32'(vecs[v].exp_words));
      if (vecs[v].exp_words > 0)
        checkOutput("burst_last_word", 32'(last_pop_dat), 32'(mem[vecs[v].exp_last_addr]));
    end

    // Second command held valid during a running burst waits for o_done.
    ready_mode = 0;
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_base  = 6'h08;
    bus.i_cmd_len   = 7'd6;
    @(posedge i_clk); #1;
    bus.i_cmd_base  = 6'h30;
    bus.i_cmd_len   = 7'd3;
    waitDone();
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b0;
    waitDone();
    checkOutput("queued_cmd_words", 32'(burst_pops), 32'd3);
    checkOutput("queued_cmd_last", 32'(last_pop_dat), 32'(mem[6'h32]));

    // Reset one cycle after the third read of an 8-word burst.
    ready_mode = 0;
    startCmd(6'h00, 7'd8);
    g = 0;
    while (burst_reads < 3 && g < 20) begin
      @(negedge i_clk);
      #1;
      g++;
    end
    checkOutput("reads_before_reset", 32'(burst_reads), 32'd3);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    inject_stray = 1'b1;
    repeat (3) @(posedge i_clk);
    checkOutput("post_reset_no_word", 32'(bus.o_dat_valid), 32'd0);
    applyStimulus(6'h20, 7'd2);
    checkOutput("post_reset_words", 32'(burst_pops), 32'd2);
    checkOutput("post_reset_last", 32'(last_pop_dat), 32'(mem[6'h21]));

    repeat (3) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
